// File: rtl/pwm_duty_ramp.sv
// Duty-code ramp controller: slews duty_out toward an accepted target by STEP
// once per PWM period, with synchronous emergency stop and async reset.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | duty_out equals stored target; ready for a new target
// RAMP_UP   | duty_out < target; add STEP on each period_tick
// RAMP_DOWN | duty_out > target; subtract STEP on each period_tick
module pwm_duty_ramp #(
  parameter int PERIOD_CYCLES = 2500,
  parameter int STEP          = 1,
  parameter int MAX_DUTY      = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] target_in,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic       estop,
  output logic [7:0] duty_out,
  output logic       busy,
  output logic       period_tick
);

  localparam int             CW    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST  = CW'(PERIOD_CYCLES - 1);
  localparam logic [8:0]     STEP9 = 9'(STEP);
  localparam logic [7:0]     STEP8 = 8'(STEP);
  localparam logic [7:0]     MAX8  = 8'(MAX_DUTY);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      duty_q, duty_d;
  logic [7:0]      target_q, target_d;
  logic [7:0]      tgt_clamped;
  logic [8:0]      up_sum;
  logic [8:0]      down_diff;
  logic            tick;
  logic            accept;

  assign tick         = (cnt_q == LAST);
  assign cnt_d        = tick ? '0 : cnt_q + CW'(1);
  assign tgt_clamped  = (target_in > MAX8) ? MAX8 : target_in;
  // 9-bit arithmetic so the step can never wrap past 255 or below 0
  assign up_sum       = {1'b0, duty_q} + STEP9;
  assign down_diff    = {1'b0, duty_q} - {1'b0, target_q};

  assign target_ready = !reset && (state_q == IDLE) && !estop;
  assign accept       = target_valid && target_ready;
  assign duty_out     = duty_q;
  assign busy         = (state_q != IDLE);
  assign period_tick  = tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      duty_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    if (estop) begin
      state_d  = IDLE;
      duty_d   = '0;
      target_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // an acceptance on a tick cycle only arms the ramp; first step is next tick
          if (accept) begin
            target_d = tgt_clamped;
            if (tgt_clamped > duty_q)      state_d = RAMP_UP;
            else if (tgt_clamped < duty_q) state_d = RAMP_DOWN;
          end
        end
        RAMP_UP: begin
          if (tick) begin
            if (up_sum >= {1'b0, target_q}) begin
              duty_d  = target_q;
              state_d = IDLE;
            end else begin
              duty_d  = up_sum[7:0];
            end
          end
        end
        RAMP_DOWN: begin
          if (tick) begin
            if (down_diff <= STEP9) begin
              duty_d  = target_q;
              state_d = IDLE;
            end else begin
              duty_d  = duty_q - STEP8;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: three instances (STEP 1, 4, MAX_DUTY)
// share clock/reset and therefore tick phase.
module tb_pwm_duty_ramp;

  localparam int P = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tin    [3];
  logic       tv     [3];
  logic       es     [3];
  logic [7:0] duty_w [3];
  logic       busy_w [3];
  logic       rdy_w  [3];
  logic       tick_w [3];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pwm_duty_ramp #(.PERIOD_CYCLES(P), .STEP(1), .MAX_DUTY(250)) u0 (
    .clock(clock), .reset(reset), .target_in(tin[0]), .target_valid(tv[0]),
    .target_ready(rdy_w[0]), .estop(es[0]), .duty_out(duty_w[0]),
    .busy(busy_w[0]), .period_tick(tick_w[0]));

  pwm_duty_ramp #(.PERIOD_CYCLES(P), .STEP(4), .MAX_DUTY(250)) u1 (
    .clock(clock), .reset(reset), .target_in(tin[1]), .target_valid(tv[1]),
    .target_ready(rdy_w[1]), .estop(es[1]), .duty_out(duty_w[1]),
    .busy(busy_w[1]), .period_tick(tick_w[1]));

  pwm_duty_ramp #(.PERIOD_CYCLES(P), .STEP(250), .MAX_DUTY(250)) u2 (
    .clock(clock), .reset(reset), .target_in(tin[2]), .target_valid(tv[2]),
    .target_ready(rdy_w[2]), .estop(es[2]), .duty_out(duty_w[2]),
    .busy(busy_w[2]), .period_tick(tick_w[2]));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < P + 2; i++) begin
      if (tick_w[0]) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) begin
      checks++;
      failures++;
      $error("FAIL tick_timeout observed=none expected=tick");
    end
  endtask

  task automatic tick_step(int u, int exp, string tag);
    wait_tick();
    step();
    chk(tag, 32'(duty_w[u]), 32'(exp));
  endtask

  task automatic accept(int u, int t);
    tin[u] = 8'(t);
    tv[u]  = 1'b1;
    chk("accept_ready", 32'(rdy_w[u]), 1);
    step();
    tv[u]  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tin[i] = '0;
      tv[i]  = 1'b0;
      es[i]  = 1'b0;
    end
    #1;
    chk("rst_duty",  32'(duty_w[0]), 0);
    chk("rst_busy",  32'(busy_w[0]), 0);
    chk("rst_tick",  32'(tick_w[0]), 0);
    chk("rst_ready", 32'(rdy_w[0]),  0);
    repeat (3) step();
    reset = 1'b0;

    // first tick P edges after release; accept target 5 on that tick cycle
    repeat (P - 2) step();
    chk("first_tick_early", 32'(tick_w[0]), 0);
    step();
    chk("first_tick", 32'(tick_w[0]), 1);
    accept(0, 5);
    chk("acc_on_tick_duty", 32'(duty_w[0]), 0);
    chk("acc_on_tick_busy", 32'(busy_w[0]), 1);
    chk("ramp_ready",       32'(rdy_w[0]),  0);
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      chk("up5_hold", 32'(duty_w[0]), 32'(k - 1));
      step();
      chk("up5_step", 32'(duty_w[0]), 32'(k));
    end
    chk("up5_busy",  32'(busy_w[0]), 0);
    chk("up5_ready", 32'(rdy_w[0]),  1);

    // STEP = MAX_DUTY reaches any target in one period
    accept(2, 200);
    tick_step(2, 200, "bigstep_up");
    chk("bigstep_up_busy", 32'(busy_w[2]), 0);
    accept(2, 3);
    tick_step(2, 3, "bigstep_dn");
    chk("bigstep_dn_busy", 32'(busy_w[2]), 0);

    // STEP=4: up to 10 then down to 1
    accept(1, 10);
    tick_step(1, 4,  "s4_up");
    tick_step(1, 8,  "s4_up");
    tick_step(1, 10, "s4_up");
    chk("s4_up_busy", 32'(busy_w[1]), 0);
    accept(1, 1);
    chk("s4_dn_busy", 32'(busy_w[1]), 1);
    tick_step(1, 6, "s4_dn");
    tick_step(1, 2, "s4_dn");
    tick_step(1, 1, "s4_dn");
    chk("s4_dn_idle", 32'(busy_w[1]), 0);

    // target_valid held high with another value during a ramp is ignored
    accept(1, 21);
    tin[1] = 8'd200;
    tv[1]  = 1'b1;
    #1;
    chk("hold_ready", 32'(rdy_w[1]), 0);
    tick_step(1, 5,  "hold_up");
    tick_step(1, 9,  "hold_up");
    tick_step(1, 13, "hold_up");
    chk("hold_ready_mid", 32'(rdy_w[1]), 0);
    tick_step(1, 17, "hold_up");
    tick_step(1, 21, "hold_up");
    tv[1] = 1'b0;
    tick_step(1, 21, "hold_final");
    chk("hold_busy", 32'(busy_w[1]), 0);

    // clamp: 255 stored as 250, never exceeds
    accept(0, 248);
    for (int k = 6; k <= 248; k++) tick_step(0, k, "up248");
    accept(0, 255);
    tick_step(0, 249, "clamp");
    tick_step(0, 250, "clamp");
    chk("clamp_busy", 32'(busy_w[0]), 0);
    tick_step(0, 250, "clamp_hold");

    // estop mid-ramp at 120, off-tick, with a competing target
    accept(0, 100);
    for (int k = 249; k >= 120; k--) tick_step(0, k, "down120");
    step();
    step();
    es[0]  = 1'b1;
    tin[0] = 8'd200;
    tv[0]  = 1'b1;
    #1;
    chk("estop_ready", 32'(rdy_w[0]), 0);
    step();
    chk("estop_duty",        32'(duty_w[0]), 0);
    chk("estop_busy",        32'(busy_w[0]), 0);
    chk("estop_ready_held",  32'(rdy_w[0]),  0);
    es[0] = 1'b0;
    tv[0] = 1'b0;
    #1;
    chk("estop_ready_rel", 32'(rdy_w[0]), 1);
    repeat (P - 5) step();
    chk("estop_phase_early", 32'(tick_w[0]), 0);
    step();
    chk("estop_phase", 32'(tick_w[0]), 1);
    step();
    chk("estop_duty_after", 32'(duty_w[0]), 0);

    // async reset mid-ramp between edges
    accept(1, 200);
    tick_step(1, 25, "pre_rst");
    #3;
    reset = 1'b1;
    #1;
    chk("arst_duty",  32'(duty_w[1]), 0);
    chk("arst_busy",  32'(busy_w[1]), 0);
    chk("arst_tick",  32'(tick_w[1]), 0);
    chk("arst_ready", 32'(rdy_w[1]),  0);
    step();
    reset = 1'b0;
    repeat (P - 2) step();
    chk("arst_tick_early", 32'(tick_w[1]), 0);
    step();
    chk("arst_first_tick", 32'(tick_w[1]), 1);
    accept(1, 0);
    chk("eq_busy",  32'(busy_w[1]), 0);
    chk("eq_duty",  32'(duty_w[1]), 0);
    chk("eq_ready", 32'(rdy_w[1]),  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
